// File: rtl/reflet_int_ctrl.sv
// Four-line nested interrupt controller: masks level lines, raises one request
// at a time to the CPU and tracks in-service handlers for nesting.
module reflet_int_ctrl #(
    parameter int                        wordsize       = 16,
    parameter int                        base_addr_size = 16,
    parameter logic [base_addr_size-1:0] base_addr      = 16'hFF10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic                      write_en,
    input  logic [wordsize-1:0]       data_in,
    output logic [wordsize-1:0]       data_out,
    input  logic [3:0]                int_lines,
    output logic                      int_req,
    output logic [1:0]                int_num,
    input  logic                      int_ack,
    input  logic                      int_ret
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [3:0]                mask_q, mask_d;
    logic [3:0]                isr_q, isr_d;
    logic [1:0]                int_num_q, int_num_d;
    logic                      ret_err_q, ret_err_d;

    logic [base_addr_size-1:0] offset_s;
    logic                      sel_s;
    logic                      reg_idx_s;
    logic                      wr_s;
    logic [3:0]                pending_s;
    logic [3:0]                above_isr_s;
    logic                      req_ok_s;
    logic                      line_live_s;
    logic                      unused_s;

    function automatic logic [3:0] lowest_onehot(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        logic [1:0] idx;
        casez (v)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    assign offset_s  = addr - base_addr;
    assign sel_s     = enable && (addr >= base_addr) && (offset_s[base_addr_size-1:1] == '0);
    assign reg_idx_s = offset_s[0];
    assign wr_s      = sel_s && write_en;

    // With ISR empty, lowest_onehot is 0 and the decrement opens every line.
    assign pending_s   = int_lines & mask_q & ~isr_q;
    assign above_isr_s = lowest_onehot(isr_q) - 4'd1;
    assign req_ok_s    = (pending_s & above_isr_s) != 4'b0000;
    assign line_live_s = int_lines[int_num_q] && mask_q[int_num_q];

    assign int_req  = (state_q == ST_REQ);
    assign int_num  = int_num_q;
    assign unused_s = ^{data_in[wordsize-1:8], data_in[6:4]};

    // Next-state: bus writes, handler return, request FSM.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        isr_d     = isr_q;
        int_num_d = int_num_q;
        ret_err_d = ret_err_q;

        if (wr_s && !reg_idx_s) begin
            mask_d = data_in[3:0];
        end else begin
            mask_d = mask_q;
        end

        if (wr_s && reg_idx_s && data_in[7]) begin
            ret_err_d = 1'b0;
        end else begin
            ret_err_d = ret_err_q;
        end

        // Return is applied to the old ISR before any acked bit is merged in.
        if (int_ret) begin
            if (isr_q != 4'b0000) begin
                isr_d = isr_q & ~lowest_onehot(isr_q);
            end else begin
                ret_err_d = 1'b1;
            end
        end else begin
            isr_d = isr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_ok_s) begin
                    state_d   = ST_REQ;
                    int_num_d = lowest_idx(pending_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_d = ST_IDLE;
                    isr_d   = isr_d | (4'b0001 << int_num_q);
                end else if (!line_live_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            mask_q    <= 4'b0000;
            isr_q     <= 4'b0000;
            int_num_q <= 2'd0;
            ret_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            isr_q     <= isr_d;
            int_num_q <= int_num_d;
            ret_err_q <= ret_err_d;
        end
    end

    // Combinational bus read mux, zero when not selected.
    always_comb begin
        data_out = {wordsize{1'b0}};
        if (sel_s) begin
            if (reg_idx_s) begin
                data_out[7:0] = {ret_err_q, int_req, int_num_q, isr_q};
            end else begin
                data_out[3:0] = mask_q;
            end
        end else begin
            data_out = {wordsize{1'b0}};
        end
    end

endmodule

// File: tb/tb_reflet_int_ctrl.sv
// Directed bench for reflet_int_ctrl: request latency, nesting, withdrawal,
// return handling, bus registers and asynchronous reset.
module tb_reflet_int_ctrl;

    localparam logic [15:0] BASE = 16'hFF10;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] addr;
    logic        write_en;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic [3:0]  int_lines;
    logic        int_req;
    logic [1:0]  int_num;
    logic        int_ack;
    logic        int_ret;

    int pass_cnt  = 0;
    int total_cnt = 0;

    reflet_int_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .addr      (addr),
        .write_en  (write_en),
        .data_in   (data_in),
        .data_out  (data_out),
        .int_lines (int_lines),
        .int_req   (int_req),
        .int_num   (int_num),
        .int_ack   (int_ack),
        .int_ret   (int_ret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        enable   = 1'b1;
        addr     = a;
        write_en = 1'b1;
        data_in  = d;
        step();
        enable   = 1'b0;
        write_en = 1'b0;
        data_in  = 16'h0000;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
        enable = 1'b1;
        addr   = a;
        #1;
        chk(tag, data_out, exp);
        enable = 1'b0;
        #1;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
    endtask

    task automatic pulse_ret();
        int_ret = 1'b1;
        step();
        int_ret = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        addr      = 16'h0000;
        write_en  = 1'b0;
        data_in   = 16'h0000;
        int_lines = 4'b0000;
        int_ack   = 1'b0;
        int_ret   = 1'b0;

        #1;
        chk("rst_int_req", {15'd0, int_req}, 16'h0000);
        chk("rst_int_num", {14'd0, int_num}, 16'h0000);
        rd_chk("rst_mask", BASE, 16'h0000);
        rd_chk("rst_status", BASE + 16'd1, 16'h0000);
        #8;
        reset = 1'b1;
        step();

        // Mask register: upper bits read zero; unselected reads are zero
        bus_write(BASE, 16'hFFFF);
        rd_chk("mask_rw", BASE, 16'h000F);
        rd_chk("out_of_range", BASE + 16'd2, 16'h0000);
        enable = 1'b0;
        addr   = BASE;
        #1;
        chk("not_enabled", data_out, 16'h0000);

        // Single request on line 2, one-cycle latency, then ack
        int_lines = 4'b0100;
        #1;
        chk("latency_req_low", {15'd0, int_req}, 16'h0000);
        step();
        chk("req2_int_req", {15'd0, int_req}, 16'h0001);
        chk("req2_int_num", {14'd0, int_num}, 16'h0002);
        rd_chk("req2_status", BASE + 16'd1, 16'h0060);
        pulse_ack();
        chk("ack2_int_req", {15'd0, int_req}, 16'h0000);
        rd_chk("ack2_status", BASE + 16'd1, 16'h0024);

        // Lower-priority line 3 is blocked by in-service line 2
        int_lines = 4'b1100;
        step();
        step();
        chk("line3_blocked", {15'd0, int_req}, 16'h0000);

        // Line 0 nests above line 2
        int_lines = 4'b0101;
        step();
        chk("nest0_int_req", {15'd0, int_req}, 16'h0001);
        chk("nest0_int_num", {14'd0, int_num}, 16'h0000);
        pulse_ack();
        rd_chk("nest0_status", BASE + 16'd1, 16'h0005);

        // Returns clear lowest ISR bit; extra return sets ret_error
        int_lines = 4'b0000;
        pulse_ret();
        rd_chk("ret1_status", BASE + 16'd1, 16'h0004);
        pulse_ret();
        pulse_ret();
        rd_chk("ret_err_status", BASE + 16'd1, 16'h0080);
        bus_write(BASE + 16'd1, 16'h0080);
        rd_chk("ret_err_clear", BASE + 16'd1, 16'h0000);

        // Higher-priority arrival during REQ leaves int_num alone
        int_lines = 4'b0100;
        step();
        int_lines = 4'b0110;
        step();
        chk("hold_int_req", {15'd0, int_req}, 16'h0001);
        chk("hold_int_num", {14'd0, int_num}, 16'h0002);
        pulse_ack();
        chk("no_req_after_ack", {15'd0, int_req}, 16'h0000);
        step();
        chk("next1_int_req", {15'd0, int_req}, 16'h0001);
        chk("next1_int_num", {14'd0, int_num}, 16'h0001);

        // Line 1 withdrawn before ack
        int_lines = 4'b0100;
        step();
        chk("withdraw_int_req", {15'd0, int_req}, 16'h0000);
        rd_chk("withdraw_status", BASE + 16'd1, 16'h0014);

        // Ack and return together: old bit 2 cleared, bit 1 set
        int_lines = 4'b0010;
        step();
        chk("rereq1_int_req", {15'd0, int_req}, 16'h0001);
        int_ack = 1'b1;
        int_ret = 1'b1;
        step();
        int_ack = 1'b0;
        int_ret = 1'b0;
        rd_chk("ack_ret_status", BASE + 16'd1, 16'h0012);

        // Asynchronous reset mid-request
        int_lines = 4'b0011;
        step();
        rd_chk("pre_reset_status", BASE + 16'd1, 16'h0042);
        #1;
        reset = 1'b0;
        #1;
        chk("async_int_req", {15'd0, int_req}, 16'h0000);
        rd_chk("async_status", BASE + 16'd1, 16'h0000);
        rd_chk("async_mask", BASE, 16'h0000);
        reset = 1'b1;

        // After release, MASK=0 holds requests off until written
        step();
        chk("post_rst_masked", {15'd0, int_req}, 16'h0000);
        bus_write(BASE, 16'h0001);
        chk("mask_write_latency", {15'd0, int_req}, 16'h0000);
        step();
        chk("post_rst_req", {15'd0, int_req}, 16'h0001);
        chk("post_rst_num", {14'd0, int_num}, 16'h0000);
        pulse_ack();

        // Ack outside REQ is ignored
        int_lines = 4'b0000;
        pulse_ack();
        rd_chk("idle_ack_status", BASE + 16'd1, 16'h0001);
        chk("idle_ack_int_req", {15'd0, int_req}, 16'h0000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/reflet_int_ctrl.md
REFLET_INT_CTRL -- requirements
Module: reflet_int_ctrl

Interface
REQ-001 SHALL take parameter wordsize, default 16, as the system bus data width.
REQ-002 SHALL take parameter base_addr_size, default 16, as the system bus address width.
REQ-003 SHALL take parameter base_addr, default 16'hFF10, as the address of register 0; registers occupy base_addr..base_addr+1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: bus access qualifier.
REQ-007 SHALL have port addr, input, base_addr_size bits: bus address.
REQ-008 SHALL have port write_en, input, 1 bit: bus write strobe.
REQ-009 SHALL have port data_in, input, wordsize bits: bus write data.
REQ-010 SHALL have port data_out, output, wordsize bits: bus read data, zero when not selected.
REQ-011 SHALL have port int_lines, input, 4 bits: level interrupt lines from the exti block (bit 0 = line 0).
REQ-012 SHALL have port int_req, output, 1 bit: interrupt request to CPU.
REQ-013 SHALL have port int_num, output, 2 bits: line number of the current request.
REQ-014 SHALL have port int_ack, input, 1 bit: CPU accepts the request (one-cycle pulse).
REQ-015 SHALL have port int_ret, input, 1 bit: CPU leaves a handler (one-cycle pulse).

Function
REQ-016 SHALL select on enable && base_addr <= addr < base_addr+2; offset = addr - base_addr.
REQ-017 SHALL implement register 0 MASK (rw, bits [3:0], upper bits read 0); line n is eligible only if MASK[n]=1.
REQ-018 SHALL implement register 1 STATUS (read): [3:0] in-service ISR, [5:4] int_num, [6] int_req, [7] ret_error; writing 1 to bit 7 clears ret_error, other bits read-only.
REQ-019 SHALL compute pending = int_lines & MASK & ~ISR; priority: lowest line index highest.
REQ-020 SHALL have FSM states IDLE and REQ; int_req = 1 exactly in REQ.
REQ-021 IDLE -> REQ when highest pending line p has index below every set ISR bit (or ISR = 0); int_num <= p registered on that edge; int_req asserts the cycle after pending qualifies (1-cycle latency).
REQ-022 SHALL hold int_num stable throughout REQ; a higher-priority arrival during REQ SHALL NOT change int_num.
REQ-023 REQ -> IDLE with ISR[int_num] <= 1 on int_ack; no new request may be raised in the cycle immediately after the ack.
REQ-024 REQ -> IDLE without touching ISR if int_lines[int_num] or MASK[int_num] drops before int_ack (request withdrawn).
REQ-025 On int_ret SHALL clear the lowest-index set ISR bit (most recently nested handler).
REQ-026 int_ret with ISR = 0 SHALL leave ISR unchanged and set sticky ret_error.
REQ-027 int_ack and int_ret in the same cycle: clear per REQ-025 on the old ISR first, then set the acked bit.
REQ-028 int_ack outside REQ SHALL be ignored.
REQ-029 Bus writes SHALL take effect on the next clk edge; reads SHALL be combinational from current register values.

Reset
REQ-030 On reset low, asynchronously: FSM=IDLE, MASK=0, ISR=0, int_num=0, int_req=0, ret_error=0; data_out reflects these values.
REQ-031 Reset asserted mid-request or mid-handler SHALL abandon all state; after release, requests re-evaluate from the reset values.

Verification
REQ-032 MASK=0xF, int_lines=0b0100 -> int_req=1, int_num=2 one cycle later; int_ack -> ISR=0b0100, int_req=0.
REQ-033 ISR=0b0100, int_lines=0b0101 -> request int_num=0 (nesting); int_lines=0b1100 -> no request for line 3.
REQ-034 In REQ for line 2, int_lines becomes 0b0110 -> int_num stays 2; after ack, line 1 requested next.
REQ-035 In REQ for line 1, line 1 drops -> int_req=0 next cycle, ISR unchanged.
REQ-036 ISR=0b0101, int_ret -> ISR=0b0100; two further int_ret -> ISR=0, STATUS[7]=1; write STATUS=0x80 -> STATUS[7]=0.
REQ-037 Reset pulsed while int_req=1, ISR=0b0010 -> int_req=0, ISR=0, MASK=0 immediately, before the next clk edge.
